// File: rtl/key_debounce.sv
// key_debounce: keypad front end for the password lock.
//
// Raw push buttons are synchronised (2 flops), sampled once per rising edge
// of the 100 Hz square wave `hz`, and debounced by a 4-state FSM per key.
// A change of level is accepted only after STABLE_CNT consecutive identical
// samples.
//
// Ports:
//   clk          system clock (100 MHz)
//   rst_n        synchronous active-low reset
//   hz           100 Hz square wave, synchronous to clk
//   key_raw      raw button pins (asynchronous)
//   key_level    debounced level, 1 = pressed
//   key_press    one-cycle pulse when a press is accepted
//   key_release  one-cycle pulse when a release is accepted
//   key_code     index of the lowest key pressed in the key_valid cycle
//   key_valid    one-cycle strobe qualifying key_code
//   key_long     one-cycle long-press pulse (0 unless LONG_PRESS_EN)
//
// Build option: define LONG_PRESS_EN to add a per-key hold counter that
// pulses key_long once per press after LONG_TICKS samples in HELD.

module key_debounce_lane #(
  parameter int STABLE_CNT = 3,
  parameter int LONG_TICKS = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_s,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_acc_press
);
  typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, REL_PEND} state_t;

  localparam int CW = $clog2(STABLE_CNT + 1);
  // Count value that, once incremented, reaches STABLE_CNT.
  localparam logic [CW-1:0] LAST = CW'(STABLE_CNT - 1);

  if (STABLE_CNT < 1 || LONG_TICKS < 1) begin : g_bad_param
    $error("key_debounce_lane: STABLE_CNT and LONG_TICKS must be >= 1");
  end

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_level;
  logic            r_press;
  logic            r_release;
  logic            w_acc_press;
  logic            w_acc_rel;

  // Accepting ticks, also needed one level up by the encoder so its output
  // lines up with key_press.
  assign w_acc_press = i_tick && i_s &&
                       ((r_state == PRESS_PEND && r_cnt == LAST) ||
                        (r_state == IDLE && STABLE_CNT == 1));
  assign w_acc_rel   = i_tick && !i_s &&
                       ((r_state == REL_PEND && r_cnt == LAST) ||
                        (r_state == HELD && STABLE_CNT == 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_acc_press;
      r_release <= w_acc_rel;
      if (w_acc_press)    r_level <= 1'b1;
      else if (w_acc_rel) r_level <= 1'b0;

      if (i_tick) begin
        case (r_state)
          IDLE: if (i_s) begin
            if (STABLE_CNT == 1) r_state <= HELD;
            else begin
              r_state <= PRESS_PEND;
              r_cnt   <= CW'(1);
            end
          end
          PRESS_PEND: begin
            if (!i_s) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else if (r_cnt == LAST) begin
              r_state <= HELD;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          HELD: if (!i_s) begin
            if (STABLE_CNT == 1) r_state <= IDLE;
            else begin
              r_state <= REL_PEND;
              r_cnt   <= CW'(1);
            end
          end
          REL_PEND: begin
            if (i_s) begin
              r_state <= HELD;
              r_cnt   <= '0;
            end else if (r_cnt == LAST) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_level     = r_level;
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_acc_press = w_acc_press;

`ifdef LONG_PRESS_EN
  localparam int LW = $clog2(LONG_TICKS + 1);

  logic [LW-1:0] r_hold;
  logic          r_long;

  // Saturates at LONG_TICKS so only one pulse is produced per press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (r_state == IDLE) begin
        r_hold <= '0;
      end else if (i_tick && i_s && r_state == HELD &&
                   r_hold != LW'(LONG_TICKS)) begin
        r_hold <= r_hold + LW'(1);
        if (r_hold == LW'(LONG_TICKS - 1)) r_long <= 1'b1;
      end
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

module key_debounce #(
  parameter int NUM_KEYS   = 4,
  parameter int STABLE_CNT = 3,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int LONG_TICKS = 100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        hz,
  input  logic [NUM_KEYS-1:0]         key_raw,
  output logic [NUM_KEYS-1:0]         key_level,
  output logic [NUM_KEYS-1:0]         key_press,
  output logic [NUM_KEYS-1:0]         key_release,
  output logic [$clog2(NUM_KEYS)-1:0] key_code,
  output logic                        key_valid,
  output logic [NUM_KEYS-1:0]         key_long
);
  localparam int CODE_W = $clog2(NUM_KEYS);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic                r_hz_d;
  logic [CODE_W-1:0]   r_code;
  logic                r_valid;
  logic                w_tick;
  logic [NUM_KEYS-1:0] w_s;
  logic [NUM_KEYS-1:0] w_acc_press;
  logic [CODE_W-1:0]   w_code_nxt;

  // Synchroniser idles at the released raw level so reset never looks
  // like a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= {NUM_KEYS{ACTIVE_LOW}};
      r_sync2 <= {NUM_KEYS{ACTIVE_LOW}};
      r_hz_d  <= 1'b0;
    end else begin
      r_sync1 <= key_raw;
      r_sync2 <= r_sync1;
      r_hz_d  <= hz;
    end
  end

  assign w_tick = hz & ~r_hz_d;
  assign w_s    = r_sync2 ^ {NUM_KEYS{ACTIVE_LOW}};

  key_debounce_lane #(
    .STABLE_CNT (STABLE_CNT),
    .LONG_TICKS (LONG_TICKS)
  ) u_lane [NUM_KEYS-1:0] (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tick      (w_tick),
    .i_s         (w_s),
    .o_level     (key_level),
    .o_press     (key_press),
    .o_release   (key_release),
    .o_long      (key_long),
    .o_acc_press (w_acc_press)
  );

  // Lowest index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    w_code_nxt = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (w_acc_press[i]) w_code_nxt = CODE_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_code  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= |w_acc_press;
      if (|w_acc_press) r_code <= w_code_nxt;
    end
  end

  assign key_code  = r_code;
  assign key_valid = r_valid;

endmodule

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Keypad front end for the password-lock design; sits directly downstream of the 100 Hz divider.
- Uses the divider's square wave `hz` as a sample strobe; all logic runs on the single system clock.
- Synchronises and debounces raw push-button inputs.
- Delivers to the lock state machine:
  - clean key levels;
  - one-clock press/release pulses;
  - an encoded key code with a valid strobe.

Parameters:
- NUM_KEYS, 4, number of push buttons.
- STABLE_CNT, 3, consecutive identical samples needed to accept a level change (30 ms at 100 Hz).
- ACTIVE_LOW, 1, 1 means raw keys read 0 when pressed; inputs are inverted internally.
- LONG_TICKS, 100, samples a key must be held for a long-press; used only with LONG_PRESS_EN.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  synchronous, active-low reset.
- hz  in  1  100 Hz square wave from the divider, synchronous to clk.
- key_raw  in  NUM_KEYS  raw button pins, asynchronous.
- key_level  out  NUM_KEYS  debounced level, 1 = pressed.
- key_press  out  NUM_KEYS  one-cycle pulse on accepted press.
- key_release  out  NUM_KEYS  one-cycle pulse on accepted release.
- key_code  out  $clog2(NUM_KEYS)  index of the pressed key.
- key_valid  out  1  one-cycle strobe qualifying key_code.
- key_long  out  NUM_KEYS  one-cycle long-press pulse; constant 0 when feature is off.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low, sampled on posedge clk.
- Reset values:
  - All outputs are 0.
  - Synchroniser flops reset to the inactive raw level (1 if ACTIVE_LOW).
  - hz_d = 0; all per-key counters = 0; all FSMs = IDLE.
- Input synchroniser: key_raw passes through a 2-flop chain, then is XORed with ACTIVE_LOW to give s[i] (1 = pressed).
- Tick generation:
  - hz_d registers hz.
  - tick = hz & ~hz_d, i.e. one clk-cycle pulse per hz rising edge.
  - Samples are taken only on tick cycles; on all other cycles counters and states hold.
- Per-key FSM states: IDLE, PRESS_PEND, HELD, REL_PEND.
  - IDLE: on tick with s=1, go to PRESS_PEND with cnt=1.
  - PRESS_PEND, on tick:
    - s=1: cnt+1. When cnt+1 == STABLE_CNT, go to HELD and clear cnt.
    - s=0: return to IDLE with cnt=0 (glitch rejected, no output).
  - HELD: on tick with s=0, go to REL_PEND with cnt=1.
  - REL_PEND, on tick:
    - s=0: cnt+1. When cnt+1 == STABLE_CNT, go to IDLE and clear cnt.
    - s=1: return to HELD.
  - If STABLE_CNT == 1, IDLE goes straight to HELD (and HELD straight to IDLE) on the first differing tick.
- Outputs:
  - key_level[i] is 1 in HELD and REL_PEND. It is registered and updates in the cycle after the accepting tick.
  - key_press[i] is high for exactly the cycle key_level[i] rises; key_release[i] for exactly the cycle it falls.
- Latency: the press edge is accepted on the STABLE_CNT-th consecutive pressed sample. Outputs appear 1 clk later, plus 2 clk of synchroniser delay ahead of sampling.
- Encoder:
  - Registered, in the same cycle as key_press.
  - When key_press != 0: key_valid=1 and key_code = index of the lowest set bit.
  - Otherwise key_valid=0 and key_code holds its last value.
  - Simultaneous presses: lowest index wins; the other keys still pulse key_press but get no code.
- Counter width: $clog2(STABLE_CNT+1). The counter never exceeds STABLE_CNT, so no wrap occurs.
- Reset mid-operation: all state clears immediately. A key held through reset is re-debounced and produces a fresh key_press STABLE_CNT ticks after reset release.
- hz stuck at either level: no ticks occur, so all state freezes; no timeout.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - Each key gets a hold counter, $clog2(LONG_TICKS+1) bits, cleared in IDLE.
  - The counter increments on each tick while in HELD.
  - When it reaches LONG_TICKS, key_long[i] pulses for one cycle and the counter saturates, giving one pulse per press.
  - Release clears the counter.
- Undefined: key_long is tied to 0 and the hold counters are not instantiated.

Test Plan:
- Bench settings for all scenarios: STABLE_CNT=3, ACTIVE_LOW=1, NUM_KEYS=4; bench drives hz with a 20-clk period.
- Reset: rst_n=0 for 5 clk with key_raw=4'b0000 -> all outputs 0 during reset. After release, key_level=4'b1111 on the 3rd tick+1 clk. key_press=4'b1111 pulses once, with key_valid=1 and key_code=0.
- Clean press: key_raw=4'b1011 held -> key_level[2] rises 1 clk after the 3rd tick. key_press=4'b0100 for 1 clk, key_valid=1, key_code=2. No further pulses while held.
- Bounce rejection: key_raw[1]=0 for 2 ticks, then 1 -> key_level, key_press and key_valid stay 0 throughout.
- Simultaneous press then release: key_raw=4'b0110 on the same clk -> key_press=4'b1001 in one cycle, key_code=0. Then key_raw=4'b1111 -> key_release=4'b1001 1 clk after the 3rd tick, key_valid=0.
- Long press (LONG_PRESS_EN, LONG_TICKS=5): hold key 3 -> key_long=4'b1000 for exactly 1 clk, 1 clk after the 5th tick in HELD, and never again while held. Without the macro, key_long=0 always.
